// File: rtl/exonbus_seq.sv
// Transfer sequencer for the shared 8-bit exonbus: queues bus-move commands and
// plays each one out as DRIVE -> LOAD -> GAP on the tri-state enables and register loads.
module exonbus_seq #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_src,
  input  logic [2:0]    cmd_dst,
  output logic          eni,
  output logic          ena,
  output logic          enb,
  output logic          enc,
  output logic          lda,
  output logic          ldb,
  output logic          ldc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   level
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int          CW         = 5;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  // command FIFO
  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;

  // sequencer
  state_t        state_reg;
  state_t        state_next;
  logic [1:0]    src_reg;
  logic [1:0]    src_next;
  logic [2:0]    dst_reg;
  logic [2:0]    dst_next;
  logic [3:0]    src_dec;

  // registered outputs
  logic [3:0]    en_next;
  logic [3:0]    en_reg;
  logic [2:0]    ld_next;
  logic [2:0]    ld_reg;
  logic          done_next;
  logic          done_reg;
  logic          busy_next;
  logic          busy_reg;
  logic          err_reg;

  assign full      = (count_reg == FULL_LEVEL);
  assign empty     = (count_reg == '0);
  assign accept    = cmd_valid && !full;
  // an all-zero load mask is consumed here and never reaches the FIFO
  assign push      = accept && (cmd_dst != 3'b000);
  assign cmd_ready = !full;
  assign level     = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_src, cmd_dst};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state logic; GAP pops directly so back-to-back commands skip IDLE
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: state_next = LOAD;
      LOAD:  state_next = GAP;
      GAP: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign {src_next, dst_next} = pop ? mem[rd_ptr_reg] : {src_reg, dst_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg <= '0;
      dst_reg <= '0;
    end else begin
      src_reg <= src_next;
      dst_reg <= dst_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_src_dec
      assign src_dec[gi] = (src_next == 2'(gi));
    end
  endgenerate

  // output logic, evaluated on the upcoming state so every output leaves a flop
  always_comb begin
    en_next   = '0;
    ld_next   = '0;
    done_next = 1'b0;
    case (state_next)
      DRIVE: en_next = src_dec;
      LOAD: begin
        en_next = src_dec;
        ld_next = dst_next;
      end
      GAP:     done_next = 1'b1;
      default: begin
        en_next   = '0;
        ld_next   = '0;
        done_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg   <= '0;
      ld_reg   <= '0;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      en_reg   <= en_next;
      ld_reg   <= ld_next;
      done_reg <= done_next;
      busy_reg <= busy_next;
      err_reg  <= accept && (cmd_dst == 3'b000);
    end
  end

  assign eni  = en_reg[0];
  assign ena  = en_reg[1];
  assign enb  = en_reg[2];
  assign enc  = en_reg[3];
  assign lda  = ld_reg[0];
  assign ldb  = ld_reg[1];
  assign ldc  = ld_reg[2];
  assign done = done_reg;
  assign busy = busy_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_exonbus_seq.sv
// Bench for exonbus_seq: models the bus registers A/B/C around the sequencer and
// checks every executed transfer against a queue of accepted commands.
module tb_exonbus_seq;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_src = 2'd0;
  logic [2:0]    cmd_dst = 3'd0;
  logic          eni, ena, enb, enc;
  logic          lda, ldb, ldc;
  logic          busy, done, err;
  logic [AW:0]   level;

  exonbus_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .eni(eni), .ena(ena), .enb(enb), .enc(enc),
    .lda(lda), .ldb(ldb), .ldc(ldc),
    .busy(busy), .done(done), .err(err), .level(level)
  );

  always #5 clk = ~clk;

  // bus datapath around the sequencer
  logic [7:0] din = 8'h00;
  logic [7:0] reg_a = 8'h00, reg_b = 8'h00, reg_c = 8'h00;
  logic [7:0] bus;
  always_comb begin
    bus = 8'h00;
    if (eni)      bus = din;
    else if (ena) bus = reg_a;
    else if (enb) bus = reg_b;
    else if (enc) bus = reg_c;
  end
  always @(posedge clk) begin
    if (lda) reg_a <= bus;
    if (ldb) reg_b <= bus;
    if (ldc) reg_c <= bus;
  end

  int total = 0;
  int bad = 0;
  logic [4:0] exp_q[$];
  logic [7:0] exp_a = 8'h00, exp_b = 8'h00, exp_c = 8'h00;

  // monitor state
  logic [3:0] prev_en = 4'b0;
  logic [3:0] mon_en;
  logic [2:0] mon_ld;
  logic [4:0] mon_e;
  logic [3:0] mon_exp_en;
  int done_cnt = 0, err_cnt = 0, cyc = 0;
  int done_cyc[$];
  logic saw_full_block = 1'b0;

  always @(negedge clk) begin
    cyc++;
    mon_en = {enc, enb, ena, eni};
    mon_ld = {ldc, ldb, lda};
    if (rst_n) begin
      total++;
      if ($countones(mon_en) > 1) begin
        bad++; $display("FAIL one_driver cyc=%0d actual en=%b required at most one bit", cyc, mon_en);
      end
      total++;
      if (prev_en != 4'b0 && mon_en != 4'b0 && mon_en != prev_en) begin
        bad++; $display("FAIL dead_cycle cyc=%0d actual en %b->%b required all-zero gap", cyc, prev_en, mon_en);
      end
      total++;
      if (cmd_ready !== (level != DEPTH)) begin
        bad++; $display("FAIL ready_vs_level cyc=%0d actual ready=%b level=%0d required ready=!full", cyc, cmd_ready, level);
      end
      if (level == DEPTH && !cmd_ready) saw_full_block = 1'b1;
      if (mon_ld != 3'b0) begin
        total++;
        if (mon_en == 4'b0 || mon_en != prev_en) begin
          bad++; $display("FAIL ld_without_drive cyc=%0d actual ld=%b en=%b prev_en=%b required same enable previous cycle", cyc, mon_ld, mon_en, prev_en);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_load cyc=%0d actual en=%b ld=%b required no transfer", cyc, mon_en, mon_ld);
        end else begin
          mon_e = exp_q.pop_front();
          mon_exp_en = 4'b0001 << mon_e[4:3];
          if ({mon_en, mon_ld} !== {mon_exp_en, mon_e[2:0]}) begin
            bad++; $display("FAIL transfer_order cyc=%0d actual en=%b ld=%b required en=%b ld=%b", cyc, mon_en, mon_ld, mon_exp_en, mon_e[2:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (err) err_cnt++;
    end
    prev_en = mon_en;
  end

  // drive one command; returns just after the accepting edge
  task automatic send(input logic [1:0] s, input logic [2:0] d, input bit keep);
    int n;
    logic [7:0] v;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!cmd_ready) begin
      bad++; $display("FAIL send_timeout actual ready=0 required ready within 50 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (d != 3'b000) begin
        exp_q.push_back({s, d});
        case (s)
          2'd0: v = din;
          2'd1: v = exp_a;
          2'd2: v = exp_b;
          default: v = exp_c;
        endcase
        if (d[0]) exp_a = v;
        if (d[1]) exp_b = v;
        if (d[2]) exp_c = v;
      end
      if (!keep) begin
        #1 cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy) begin
      bad++; $display("FAIL idle_timeout actual busy=1 required busy=0 within 100 cycles");
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL pending_transfers actual=%0d required=0", exp_q.size());
    end
  endtask

  task automatic check_regs(input string tag);
    total++;
    if ({reg_a, reg_b, reg_c} !== {exp_a, exp_b, exp_c}) begin
      bad++; $display("FAIL regs_%s actual A=%h B=%h C=%h required A=%h B=%h C=%h", tag, reg_a, reg_b, reg_c, exp_a, exp_b, exp_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({eni, ena, enb, enc, lda, ldb, ldc, done, err, busy, cmd_ready, level} !== {11'b0, 1'b1, 3'd0}) begin
      bad++; $display("FAIL reset_state actual en=%b ld=%b done=%b err=%b busy=%b ready=%b level=%0d required zeros ready=1 level=0",
                      {enc, enb, ena, eni}, {ldc, ldb, lda}, done, err, busy, cmd_ready, level);
    end
  endtask

  task automatic test_single();
    din = 8'hAA;
    send(2'd0, 3'b001, 0);
    @(negedge clk);
    total++;
    if ({eni, lda, done, level} !== {3'b000, 3'd1}) begin
      bad++; $display("FAIL single_e0 actual eni=%b lda=%b done=%b level=%0d required 0 0 0 1", eni, lda, done, level);
    end
    @(negedge clk);
    total++;
    if ({eni, lda, done, level} !== {3'b100, 3'd0}) begin
      bad++; $display("FAIL single_drive actual eni=%b lda=%b done=%b level=%0d required 1 0 0 0", eni, lda, done, level);
    end
    @(negedge clk);
    total++;
    if ({eni, lda, done} !== 3'b110) begin
      bad++; $display("FAIL single_load actual eni=%b lda=%b done=%b required 1 1 0", eni, lda, done);
    end
    @(negedge clk);
    total++;
    if ({eni, lda, done, reg_a} !== {3'b001, 8'hAA}) begin
      bad++; $display("FAIL single_gap actual eni=%b lda=%b done=%b A=%h required 0 0 1 aa", eni, lda, done, reg_a);
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL single_after actual done=%b busy=%b required 0 0", done, busy);
    end
    wait_idle();
    check_regs("single");
  endtask

  task automatic test_multi();
    int ena_cycles, ldbc_cycles, split_cycles;
    din = 8'h5C;
    send(2'd0, 3'b001, 0);
    wait_idle();
    din = 8'h00;
    ena_cycles = 0; ldbc_cycles = 0; split_cycles = 0;
    send(2'd1, 3'b110, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ena) ena_cycles++;
      if (ldb && ldc) ldbc_cycles++;
      if (ldb != ldc || lda) split_cycles++;
    end
    total++;
    if (ena_cycles != 2 || ldbc_cycles != 1 || split_cycles != 0) begin
      bad++; $display("FAIL multi_timing actual ena=%0d ldbc=%0d stray=%0d required 2 1 0", ena_cycles, ldbc_cycles, split_cycles);
    end
    wait_idle();
    total++;
    if ({reg_a, reg_b, reg_c} !== {8'h5C, 8'h5C, 8'h5C}) begin
      bad++; $display("FAIL multi_regs actual A=%h B=%h C=%h required 5c 5c 5c", reg_a, reg_b, reg_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] srcs [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [2:0] dsts [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    int d0;
    din = 8'h3C;
    d0 = done_cnt;
    saw_full_block = 1'b0;
    done_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      send(srcs[i], dsts[i], i != 5);
    end
    wait_idle();
    total++;
    if (!saw_full_block) begin
      bad++; $display("FAIL backpressure actual no ready drop seen required ready=0 at level=4");
    end
    total++;
    if (done_cnt - d0 != 6) begin
      bad++; $display("FAIL b2b_done_count actual=%0d required=6", done_cnt - d0);
    end
    total++;
    if (done_cyc.size() != 6 || done_cyc[done_cyc.size()-1] - done_cyc[0] != 15) begin
      bad++; $display("FAIL b2b_throughput actual pulses=%0d span=%0d required 6 pulses span 15",
                      done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[done_cyc.size()-1] - done_cyc[0] : -1);
    end
    check_regs("b2b");
  endtask

  task automatic test_illegal();
    int d0, e0, drv;
    d0 = done_cnt; e0 = err_cnt; drv = 0;
    send(2'd2, 3'b000, 0);
    @(negedge clk);
    total++;
    if ({err, level, busy} !== {1'b1, 3'd0, 1'b0}) begin
      bad++; $display("FAIL illegal_err actual err=%b level=%0d busy=%b required 1 0 0", err, level, busy);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL illegal_pulse actual err=%b required 0 in second cycle", err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({eni, ena, enb, enc} != 4'b0) drv++;
    end
    total++;
    if (drv != 0 || done_cnt != d0 || err_cnt - e0 != 1) begin
      bad++; $display("FAIL illegal_quiet actual drive=%0d done=%0d err=%0d required 0 0 1", drv, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] sa, sb, sc;
    int d0, drv;
    sa = exp_a; sb = exp_b; sc = exp_c;
    din = 8'h77;
    send(2'd0, 3'b100, 1);
    send(2'd1, 3'b001, 1);
    send(2'd2, 3'b010, 0);
    @(negedge clk);
    total++;
    if ({eni, ldc, level} !== {2'b11, 3'd2}) begin
      bad++; $display("FAIL midreset_setup actual eni=%b ldc=%b level=%0d required 1 1 2", eni, ldc, level);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({eni, ena, enb, enc, lda, ldb, ldc, done, busy, level} !== 12'b0) begin
      bad++; $display("FAIL midreset_async actual en=%b ld=%b done=%b busy=%b level=%0d required all 0",
                      {enc, enb, ena, eni}, {ldc, ldb, lda}, done, busy, level);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_a = sa; exp_b = sb; exp_c = sc;
    @(negedge clk);
    total++;
    if ({level, busy, cmd_ready} !== {3'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL midreset_flush actual level=%0d busy=%b ready=%b required 0 0 1", level, busy, cmd_ready);
    end
    d0 = done_cnt; drv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({eni, ena, enb, enc} != 4'b0) drv++;
    end
    total++;
    if (drv != 0 || done_cnt != d0) begin
      bad++; $display("FAIL midreset_dropped actual drive=%0d done=%0d required 0 0", drv, done_cnt - d0);
    end
    check_regs("midreset");
    send(2'd3, 3'b001, 0);
    wait_idle();
    check_regs("postreset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
